// File: rtl/motor_pwm_gen_if.sv
// motor_pwm_gen_if: control/status bundle between the register file
// (master) and one per-motor PWM generator (slave).
interface motor_pwm_gen_if;
  logic       enable;
  logic       brake;
  logic       direction;
  logic [4:0] pwm;
  logic       fault;
  logic       pwm_out;
  logic       dir_out;
  logic       brake_out;
  logic [4:0] cur_duty;
  logic       busy;

  modport master (
    output enable, brake, direction, pwm, fault,
    input  pwm_out, dir_out, brake_out, cur_duty, busy
  );

  modport slave (
    input  enable, brake, direction, pwm, fault,
    output pwm_out, dir_out, brake_out, cur_duty, busy
  );
endinterface

// File: rtl/motor_pwm_gen.sv
// motor_pwm_gen: per-motor PWM generator driving an H-bridge.
// Duty ramps one step per RAMP_PERIODS PWM periods toward the target,
// reversals first ramp to zero, brake/fault force the bridge into brake.
// Optional build macro: PWM_FAULT_LATCH_EN makes a fault sticky until
// software drops enable while the fault input is low.
module motor_pwm_gen #(
  parameter int CLK_DIV      = 8,
  parameter int RAMP_PERIODS = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  motor_pwm_gen_if.slave   bus
);

  localparam int PS_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int RAMP_W = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
  localparam logic [PS_W-1:0]   PS_MAX   = PS_W'(CLK_DIV - 1);
  localparam logic [RAMP_W-1:0] RAMP_MAX = RAMP_W'(RAMP_PERIODS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    REVERSE = 2'd2,
    BRAKE   = 2'd3
  } state_t;

  state_t              state_reg, state_next;
  logic [1:0]          rst_sync_reg;
  logic                rst_n_sync;
  logic [PS_W-1:0]     prescaler_reg, prescaler_next;
  logic [4:0]          cnt_reg, cnt_next;
  logic [RAMP_W-1:0]   ramp_reg, ramp_next;
  logic [4:0]          duty_reg, duty_next, step_duty;
  logic                dir_reg, dir_next;
  logic                brake_out_reg, brake_out_next;
  logic                pwm_out_reg, pwm_out_next;
  logic                tick, boundary;
  logic                fault_active, go_brake;
  logic                reversal_pending;
  logic [4:0]          eff_target;

  // Reset asserts immediately and releases two clocks after reset_n rises.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rst_sync_reg <= 2'b00;
    else          rst_sync_reg <= {rst_sync_reg[0], 1'b1};
  end
  assign rst_n_sync = rst_sync_reg[1];

`ifdef PWM_FAULT_LATCH_EN
  logic fault_latch_reg;

  // Sticky fault: held until enable is dropped with the fault input low.
  always_ff @(posedge clock or negedge rst_n_sync) begin
    if (!rst_n_sync)      fault_latch_reg <= 1'b0;
    else if (bus.fault)   fault_latch_reg <= 1'b1;
    else if (!bus.enable) fault_latch_reg <= 1'b0;
  end
  // Raw fault is ORed in so the first fault clock already brakes.
  assign fault_active = bus.fault | fault_latch_reg;
`else
  assign fault_active = bus.fault;
`endif

  assign go_brake = bus.brake | fault_active;
  assign tick     = (prescaler_reg == PS_MAX);
  assign boundary = tick && (cnt_reg == 5'd31);

  assign reversal_pending = (state_reg == REVERSE) ||
                            ((state_reg == RUN) && (bus.direction != dir_reg));
  assign eff_target = (!bus.enable || reversal_pending) ? 5'd0 : bus.pwm;

  // Next-state and datapath: brake dominates, otherwise ramp/reverse per state.
  always_comb begin
    state_next     = state_reg;
    prescaler_next = tick ? '0 : prescaler_reg + 1'b1;
    cnt_next       = tick ? cnt_reg + 5'd1 : cnt_reg;
    ramp_next      = ramp_reg;
    step_duty      = duty_reg;
    dir_next       = dir_reg;
    brake_out_next = brake_out_reg;

    // Ramp counter steps duty toward the effective target, never past it.
    if (boundary) begin
      if (ramp_reg == RAMP_MAX) begin
        ramp_next = '0;
        if (duty_reg < eff_target)      step_duty = duty_reg + 5'd1;
        else if (duty_reg > eff_target) step_duty = duty_reg - 5'd1;
      end else begin
        ramp_next = ramp_reg + 1'b1;
      end
    end
    duty_next = step_duty;

    if (go_brake) begin
      state_next     = BRAKE;
      duty_next      = 5'd0;
      brake_out_next = 1'b1;
      prescaler_next = '0;
      cnt_next       = 5'd0;
      ramp_next      = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          // Duty is zero here, so the direction can be taken over safely.
          if (bus.enable) begin
            state_next = RUN;
            dir_next   = bus.direction;
          end else if (boundary) begin
            dir_next = bus.direction;
          end
        end
        RUN: begin
          if (bus.direction != dir_reg)        state_next = REVERSE;
          else if (!bus.enable && duty_reg == 5'd0) state_next = IDLE;
        end
        REVERSE: begin
          // Flip only on the boundary where the applied duty becomes zero.
          if (bus.direction == dir_reg) begin
            state_next = RUN;
          end else if (boundary && step_duty == 5'd0) begin
            dir_next   = bus.direction;
            state_next = RUN;
          end
        end
        BRAKE: begin
          state_next     = IDLE;
          brake_out_next = 1'b0;
        end
        default: state_next = IDLE;
      endcase
    end

    pwm_out_next = (state_next != BRAKE) && (cnt_reg < duty_reg);
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      state_reg     <= IDLE;
      prescaler_reg <= '0;
      cnt_reg       <= 5'd0;
      ramp_reg      <= '0;
      duty_reg      <= 5'd0;
      dir_reg       <= 1'b0;
      brake_out_reg <= 1'b0;
      pwm_out_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      prescaler_reg <= prescaler_next;
      cnt_reg       <= cnt_next;
      ramp_reg      <= ramp_next;
      duty_reg      <= duty_next;
      dir_reg       <= dir_next;
      brake_out_reg <= brake_out_next;
      pwm_out_reg   <= pwm_out_next;
    end
  end

  assign bus.pwm_out   = pwm_out_reg;
  assign bus.dir_out   = dir_reg;
  assign bus.brake_out = brake_out_reg;
  assign bus.cur_duty  = duty_reg;
  // Held low during reset so every output reads zero.
  assign bus.busy      = rst_n_sync & ((duty_reg != eff_target) | reversal_pending);

endmodule

// File: tb/tb_motor_pwm_gen.sv
// tb_motor_pwm_gen: directed test of motor_pwm_gen with CLK_DIV=2,
// RAMP_PERIODS=1 (64-clock PWM period, one duty step per period).
module tb_motor_pwm_gen;

  logic clock;
  logic reset_n;
  int   compared;
  int   mismatched;

  motor_pwm_gen_if bus ();

  motor_pwm_gen #(
    .CLK_DIV      (2),
    .RAMP_PERIODS (1)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input int observed, input int expected);
    compared++;
    $display("[%0t] %s observed=%0d expected=%0d", $time, tag, observed, expected);
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Wait (bounded) for cur_duty to change; returns clocks waited.
  task automatic wait_change(output int cyc);
    logic [4:0] prev;
    prev = bus.cur_duty;
    cyc  = 0;
    while (bus.cur_duty === prev && cyc < 200) begin
      @(negedge clock);
      cyc++;
    end
  endtask

  task automatic wait_pwm_high();
    int cyc;
    cyc = 0;
    while (bus.pwm_out !== 1'b1 && cyc < 200) begin
      @(negedge clock);
      cyc++;
    end
    check("pwm_high_seen", int'(bus.pwm_out), 1);
  endtask

  task automatic count_high(input int n, output int highs);
    highs = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (bus.pwm_out === 1'b1) highs++;
    end
  endtask

  // Ramp until cur_duty equals target (bounded number of steps).
  task automatic ramp_to(input int target);
    int cyc;
    for (int i = 0; i < 40 && int'(bus.cur_duty) != target; i++) wait_change(cyc);
  endtask

  initial begin
    int cyc;
    int highs;
    compared   = 0;
    mismatched = 0;
    reset_n       = 1'b0;
    bus.enable    = 1'b0;
    bus.brake     = 1'b0;
    bus.direction = 1'b0;
    bus.pwm       = 5'd0;
    bus.fault     = 1'b0;
    repeat (4) @(negedge clock);
    check("rst_pwm_out",   int'(bus.pwm_out),   0);
    check("rst_dir_out",   int'(bus.dir_out),   0);
    check("rst_brake_out", int'(bus.brake_out), 0);
    check("rst_cur_duty",  int'(bus.cur_duty),  0);
    check("rst_busy",      int'(bus.busy),      0);

    // 1: ramp up to 4 in direction 0
    reset_n    = 1'b1;
    bus.enable = 1'b1;
    bus.pwm    = 5'd4;
    for (int k = 1; k <= 4; k++) begin
      wait_change(cyc);
      check($sformatf("t1_duty%0d", k), int'(bus.cur_duty), k);
      if (k > 1) check($sformatf("t1_gap%0d", k), cyc, 64);
      if (k == 1) check("t1_busy_ramping", int'(bus.busy), 1);
    end
    check("t1_busy_done", int'(bus.busy), 0);
    count_high(64, highs);
    check("t1_high_count", highs, 8);
    check("t1_dir_out", int'(bus.dir_out), 0);

    // 2: reversal ramps down, flips at zero, ramps back up
    bus.direction = 1'b1;
    for (int k = 3; k >= 0; k--) begin
      wait_change(cyc);
      check($sformatf("t2_down%0d", k), int'(bus.cur_duty), k);
      if (k == 3) check("t2_dir_hold", int'(bus.dir_out), 0);
      if (k == 2) check("t2_gap", cyc, 64);
    end
    check("t2_dir_flip", int'(bus.dir_out), 1);
    check("t2_pwm_low_at_flip", int'(bus.pwm_out), 0);
    for (int k = 1; k <= 4; k++) begin
      wait_change(cyc);
      check($sformatf("t2_up%0d", k), int'(bus.cur_duty), k);
    end

    // 3: brake mid-pulse
    wait_pwm_high();
    bus.brake = 1'b1;
    @(negedge clock);
    check("t3_pwm_out",   int'(bus.pwm_out),   0);
    check("t3_brake_out", int'(bus.brake_out), 1);
    check("t3_cur_duty",  int'(bus.cur_duty),  0);
    repeat (5) @(negedge clock);
    bus.brake = 1'b0;
    @(negedge clock);
    check("t3_brake_rel", int'(bus.brake_out), 0);
    wait_change(cyc);
    check("t3_first_gap", cyc + 1, 64);
    check("t3_duty1", int'(bus.cur_duty), 1);
    ramp_to(4);
    check("t3_duty4", int'(bus.cur_duty), 4);

    // 4: one-clock fault pulse
    bus.fault = 1'b1;
    @(negedge clock);
    bus.fault = 1'b0;
    check("t4_brake_on", int'(bus.brake_out), 1);
    check("t4_duty0",    int'(bus.cur_duty),  0);
`ifdef PWM_FAULT_LATCH_EN
    repeat (5) @(negedge clock);
    check("t4_latched", int'(bus.brake_out), 1);
    bus.enable = 1'b0;
    repeat (2) @(negedge clock);
    check("t4_brake_off", int'(bus.brake_out), 0);
    bus.enable = 1'b1;
    wait_change(cyc);
    check("t4_duty1", int'(bus.cur_duty), 1);
`else
    @(negedge clock);
    check("t4_brake_off", int'(bus.brake_out), 0);
    wait_change(cyc);
    check("t4_first_gap", cyc + 1, 64);
    check("t4_duty1", int'(bus.cur_duty), 1);
`endif
    ramp_to(4);
    check("t4_duty4", int'(bus.cur_duty), 4);

    // 5: full and zero duty
    bus.pwm = 5'd31;
    ramp_to(31);
    check("t5_duty31", int'(bus.cur_duty), 31);
    count_high(64, highs);
    check("t5_high31", highs, 62);
    check("t5_busy31", int'(bus.busy), 0);
    bus.pwm = 5'd0;
    ramp_to(0);
    check("t5_duty0", int'(bus.cur_duty), 0);
    count_high(128, highs);
    check("t5_high0", highs, 0);

    // 6: async reset mid-pulse at duty 31
    bus.pwm = 5'd31;
    ramp_to(31);
    check("t6_duty31", int'(bus.cur_duty), 31);
    wait_pwm_high();
    #2 reset_n = 1'b0;
    #1;
    check("t6_pwm_out",   int'(bus.pwm_out),   0);
    check("t6_dir_out",   int'(bus.dir_out),   0);
    check("t6_brake_out", int'(bus.brake_out), 0);
    check("t6_cur_duty",  int'(bus.cur_duty),  0);
    check("t6_busy",      int'(bus.busy),      0);
    bus.enable    = 1'b0;
    bus.pwm       = 5'd0;
    bus.direction = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (6) @(negedge clock);
    check("t6_post_duty", int'(bus.cur_duty), 0);
    check("t6_post_busy", int'(bus.busy),     0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
